// File: rtl/sha_2x_256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_2x_256_pkg
// Brief    : Shared SHA-2/256 constants, types and round helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package sha_2x_256_pkg;

    typedef logic [31:0]        word_t;
    typedef logic [7:0][31:0]   state8_t;   // index 0 = a / H0
    typedef logic [15:0][31:0]  window_t;   // index 0 = oldest word W_t

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } state_t;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Listed H7 first so that element [0] is H0.
    localparam state8_t IV256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    localparam state8_t IV224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t shr(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic word_t small_sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

    // SHA-224 truncates to seven words; the last word is presented as zero.
    function automatic logic [255:0] hash_pack(input state8_t h, input logic sha224);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[255 - 32*i -: 32] = h[i];
        end
        if (sha224) begin
            r[31:0] = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_2x_256_round.sv
`default_nettype none
// ============================================================================
// Module   : sha_2x_256_round
// Brief    : One combinational SHA-256 round plus schedule window slide.
// Revision : 1.0 - initial release
// ============================================================================
module sha_2x_256_round
    import sha_2x_256_pkg::*;
(
    input  state8_t i_v,
    input  window_t i_win,
    input  word_t   i_k,
    output state8_t o_v,
    output window_t o_win
);

    word_t w_t1;
    word_t w_t2;
    word_t w_next;

    always_comb begin
        w_t1   = i_v[7] + big_sig1(i_v[4]) + ch(i_v[4], i_v[5], i_v[6]) + i_k + i_win[0];
        w_t2   = big_sig0(i_v[0]) + maj(i_v[0], i_v[1], i_v[2]);
        // W_(t+16) enters at the top as W_t leaves at the bottom.
        w_next = small_sig1(i_win[14]) + i_win[9] + small_sig0(i_win[1]) + i_win[0];
        o_v    = {i_v[6], i_v[5], i_v[4], i_v[3] + w_t1,
                  i_v[2], i_v[1], i_v[0], w_t1 + w_t2};
        o_win  = {w_next, i_win[15:1]};
    end

endmodule
`default_nettype wire

// File: rtl/sha_2x_256.sv
`default_nettype none
// ============================================================================
// Module   : sha_2x_256
// Brief    : SHA-256/SHA-224 block compression engine, UNROLL rounds per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sha_2x_256
    import sha_2x_256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] Data,
    input  logic         First,
    input  logic         Mode,
    input  logic         Enable,
    output logic         Busy,
    output logic [255:0] Hash,
    output logic         Ready
);

    localparam logic [5:0] c_STEP      = 6'(UNROLL);
    localparam logic [5:0] c_LAST_ITER = 6'(64 - UNROLL);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("sha_2x_256: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           w_last;
    logic [5:0]     r_iter;
    logic           r_mode;
    logic           r_ready;
    state8_t        r_h;
    state8_t        r_v;
    window_t        r_win;
    logic [255:0]   r_hash;
    state8_t        w_h_init;
    state8_t        w_h_sum;
    state8_t        w_v_chain   [UNROLL+1];
    window_t        w_win_chain [UNROLL+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Enable) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (r_iter == c_LAST_ITER) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_v_chain[0]   = r_v;
    assign w_win_chain[0] = r_win;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        sha_2x_256_round u_round (
            .i_v   (w_v_chain[gi]),
            .i_win (w_win_chain[gi]),
            .i_k   (K256[r_iter + 6'(gi)]),
            .o_v   (w_v_chain[gi+1]),
            .o_win (w_win_chain[gi+1])
        );
    end

    always_comb begin
        w_h_init = r_h;
        if (First) begin
            w_h_init = Mode ? IV224 : IV256;
        end
        w_h_sum = r_h;
        for (int i = 0; i < 8; i++) begin
            w_h_sum[i] = r_h[i] + w_v_chain[UNROLL][i];
        end
    end

    // The Hash register only moves on the final round, so loading a new IV
    // into H at accept never disturbs the previously delivered digest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iter  <= '0;
            r_mode  <= 1'b0;
            r_ready <= 1'b0;
            r_h     <= IV256;
            r_v     <= '0;
            r_win   <= '0;
            r_hash  <= hash_pack(IV256, 1'b0);
        end else begin
            r_ready <= w_last;
            if (w_accept) begin
                r_win  <= Data;
                r_h    <= w_h_init;
                r_v    <= w_h_init;
                r_iter <= '0;
                if (First) begin
                    r_mode <= Mode;
                end
            end else if (r_state == ST_ROUND) begin
                r_v   <= w_v_chain[UNROLL];
                r_win <= w_win_chain[UNROLL];
                if (w_last) begin
                    r_h    <= w_h_sum;
                    r_hash <= hash_pack(w_h_sum, r_mode);
                    r_iter <= '0;
                end else begin
                    r_iter <= r_iter + c_STEP;
                end
            end
        end
    end

    assign Busy  = (r_state == ST_ROUND);
    assign Ready = r_ready;
    assign Hash  = r_hash;

endmodule
`default_nettype wire

// File: doc/sha_2x_256.md
# sha_2x_256

Parametrised SHA-2/256-family compression engine and successor to the 80-entry-schedule SHA-1 core. It hashes one pre-padded 512-bit block per request and chains blocks of a multi-block message. It supports SHA-256 and SHA-224 selectable per message, and a build-time number of rounds per clock. It sits between the padding/block-feeder logic and the digest consumer, with the same Data/Enable/Hash/Ready style as the SHA-1 core plus a Busy indication.

## Interface
- UNROLL, default 1: rounds computed per clock; legal values 1, 2, 4, 8, 16.
- clk  input  1  clock, rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- Data  input  512  padded message block; word i = Data[32i+31:32i], word 0 is W0.
- First  input  1  1 = first block of a new message (load IV); 0 = chain from current H.
- Mode  input  1  0 = SHA-256, 1 = SHA-224. Sampled only when First=1.
- Enable  input  1  start request. Accepted only while Busy=0.
- Busy  output  1  high from the accept edge until the final-round edge.
- Hash  output  256  digest. SHA-256: {H0..H7}. SHA-224: {H0..H6, 32'h0}.
- Ready  output  1  one-cycle pulse when Hash holds a new block result.

## Operation
- State machine IDLE -> ROUND -> IDLE. Iteration counter `iter` is 6 bits, counts rounds 0..63, and advances by UNROLL per cycle.
- IDLE, Enable=1, at edge:
  - Latch the 16-word schedule window from Data.
  - If First=1: latch Mode and set H to IV224 or IV256 per Mode.
  - Load working vars a..h from the (new) H.
  - iter=0, Busy=1, go to ROUND.
- ROUND, each edge:
  - Apply UNROLL chained rounds t = iter .. iter+UNROLL-1 using K256[t].
  - The schedule is a 16-word sliding window. For t<16, W_t is window word t. For t≥16, W_t = σ1(W_t-2) + W_t-7 + σ0(W_t-15) + W_t-16.
  - Each round shifts one word out of the window and the new word in.
  - All adds are mod 2^32.
- Last ROUND edge (iter+UNROLL = 64):
  - Hi <= Hi + working var i for all 8 words.
  - Ready <= 1, Busy <= 0, iter <= 0, go to IDLE.
- Enable while Busy=1 is ignored, with no queuing; the feeder must wait for Busy=0.
- First=0 with no prior message since reset chains from the reset H, which is IV256 in SHA-256 mode.
- Mode is held in a register. A Mode change with First=0 is ignored.
- SHA-224 mode: Hash[31:0] is forced to 0. H7 is still computed internally for chaining.

## Timing
- Reset values: Busy=0, Ready=0, state IDLE, iter=0, Mode register=0, H=IV256. Hash therefore resets to 6a09e667…5be0cd19.
- Reset asserted mid-block aborts the block and returns all registers to their reset values immediately. Ready is never pulsed for the aborted block.
- Latency with N = 64/UNROLL: the block is accepted at edge e0, and Ready is high for the single cycle after edge eN. Busy is high for cycles e0..eN.
- Hash is stable from eN until the next final-round edge. It is not altered during ROUND because H updates only at the final edge.
- Back-to-back: Enable high in the Ready cycle is accepted at that same edge, so throughput is one block per N+1 cycles.
- Ready is registered; Busy and Hash are registered outputs with no combinational path from inputs.

## Structure
- Add to the shared sha_const package:
  - K256[0:63] table.
  - IV256 and IV224 8-word constants.
  - ROTR, SHR, CH, MAJ, Σ0, Σ1, σ0, σ1 functions.
  - State encoding localparams.
- Sub-module sha_2x_256_round: purely combinational single round that computes (a..h, W window) into (a'..h', window'). Instantiate it UNROLL times in a generate chain.
- Add an elaboration-time check rejecting illegal UNROLL.

## Test plan
- SHA-256 "abc", UNROLL=1, First=1, Mode=0. Stimulus: Data[31:0]=61626380, Data[511:480]=00000018, all other words 0. Required: Ready pulse exactly 64 cycles after the accept edge, Hash=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- SHA-224 "abc", Mode=1, same block. Required: Hash=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block 448-bit "abcdbcdecdef…nopq" (First=1 then First=0), run at UNROLL 1, 4 and 16. Required: final Hash=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with block latency 64, 16 and 4 cycles respectively.
- Empty message, SHA-256. Stimulus: Data[31:0]=80000000, all other words 0. Required: Hash=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Then Enable again during Busy: it must be ignored, and exactly one Ready is produced.
- Back-to-back: Enable held continuously with the "abc" block. Required: Ready pulses every 65 cycles at UNROLL=1, and each result is correct.
- Assert rst at round 30 of a block, then release. Required: Busy=0, Ready=0 and Hash=IV256 immediately. A subsequent "abc" block then gives the correct digest.
